// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared constants and helpers for the debounce bank.
//   - DB_DEPTH_DEF : default number of equal samples needed to change level
//   - DB_SYNC_DEF  : default synchroniser depth
//   - DB_HOLD_DEF  : default long-press threshold in enable ticks (1 s @ 1 kHz)
//   - clog2()      : constant ceiling-log2, used to size the hold counter
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DB_DEPTH_DEF = 8;
    localparam int DB_SYNC_DEF  = 2;
    localparam int DB_HOLD_DEF  = 1000;

    // Ceiling log2; clog2(1) = 0, clog2(6) = 3, clog2(1001) = 10.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//   One debounce channel: synchroniser, DEPTH-sample filter, clean level flop,
//   registered edge pulses and a saturating hold counter for long presses.
//
// Ports
//   Clk100MHz : system clock
//   reset_n   : synchronous, active-low reset (clears every register)
//   en_i      : one-clock sample enable (nominally 1 kHz)
//   sig_i     : raw asynchronous input
//   clean_o   : debounced level
//   rise_o    : one-clock pulse, one clock after clean_o goes 0->1
//   fall_o    : one-clock pulse, one clock after clean_o goes 1->0
//   long_o    : one-clock pulse once a press has lasted HOLD_TICKS ticks
//
// Enable semantics: en_i is a plain qualifier, sampled on every rising edge.
// Each clock it is high counts as one sample, including back-to-back highs.
// -----------------------------------------------------------------------------
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DEPTH       = DB_DEPTH_DEF,
    parameter int SYNC_STAGES = DB_SYNC_DEF,
    parameter int HOLD_TICKS  = DB_HOLD_DEF
) (
    input  logic Clk100MHz,
    input  logic reset_n,
    input  logic en_i,
    input  logic sig_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int             CW     = clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0]  HOLD_C = CW'(HOLD_TICKS);

    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic [DEPTH-1:0]       shift_q, shift_d;
    logic                   clean_q, clean_d;
    logic                   clean_dly_q;
    logic                   rise_q,  rise_d;
    logic                   fall_q,  fall_d;
    logic [CW-1:0]          cnt_q,   cnt_d;
    logic                   at_hold;
    logic                   at_hold_dly_q;
    logic                   long_q,  long_d;
    logic                   s_sync;

    assign s_sync  = sync_q[SYNC_STAGES-1];
    assign at_hold = (cnt_q == HOLD_C);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        shift_d = shift_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;

        if (en_i) begin
            shift_d = {shift_q[DEPTH-2:0], s_sync};
            // Decision uses the register as it stood before this sample.
            if (&shift_q) begin
                clean_d = 1'b1;
            end else if (~|shift_q) begin
                clean_d = 1'b0;
            end
            // Counter looks at the clean level before this tick's update.
            if (!clean_q) begin
                cnt_d = '0;
            end else if (cnt_q < HOLD_C) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Edge pulses are evaluated every clock, so they are never stretched
        // by a long enable.
        rise_d = clean_q & ~clean_dly_q;
        fall_d = ~clean_q & clean_dly_q;

        // The counter saturates, so the first clock at the threshold is the
        // only one that can fire; one shot per press.
        long_d = at_hold & ~at_hold_dly_q;
    end

    always_ff @(posedge Clk100MHz) begin
        if (!reset_n) begin
            sync_q        <= '0;
            shift_q       <= '0;
            clean_q       <= 1'b0;
            clean_dly_q   <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            cnt_q         <= '0;
            at_hold_dly_q <= 1'b0;
            long_q        <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            shift_q       <= shift_d;
            clean_q       <= clean_d;
            clean_dly_q   <= clean_q;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            cnt_q         <= cnt_d;
            at_hold_dly_q <= at_hold;
            long_q        <= long_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign long_o  = long_q;

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   NUM_CH independent debounce channels sharing one clock, reset and sample
//   enable. Sits between the raw button/switch pins and the game FSM.
//
// Ports
//   Clk100MHz  : system clock
//   reset_n    : synchronous, active-low reset
//   Clk1KHzEn  : one-clock sample enable, nominally 1 kHz
//   sig        : raw asynchronous inputs, bit i = channel i
//   sig_clean  : debounced levels
//   rise_pulse : one-clock pulse per clean 0->1 change
//   fall_pulse : one-clock pulse per clean 1->0 change
//   long_press : one-clock pulse when a press has lasted HOLD_TICKS ticks
//
// All outputs come straight from flops; nothing combinational from sig.
// -----------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = DB_DEPTH_DEF,
    parameter int SYNC_STAGES = DB_SYNC_DEF,
    parameter int HOLD_TICKS  = DB_HOLD_DEF
) (
    input  logic              Clk100MHz,
    input  logic              reset_n,
    input  logic              Clk1KHzEn,
    input  logic [NUM_CH-1:0] sig,
    output logic [NUM_CH-1:0] sig_clean,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] long_press
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEPTH       (DEPTH),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_TICKS  (HOLD_TICKS)
        ) u_ch (
            .Clk100MHz (Clk100MHz),
            .reset_n   (reset_n),
            .en_i      (Clk1KHzEn),
            .sig_i     (sig[i]),
            .clean_o   (sig_clean[i]),
            .rise_o    (rise_pulse[i]),
            .fall_o    (fall_pulse[i]),
            .long_o    (long_press[i])
        );
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer for board push-buttons and switches, sitting between the raw pins and the game FSM.
- Each channel synchronises its raw input into the Clk100MHz domain. It then filters the input over DEPTH samples taken on the shared 1 kHz enable.
- Per channel it produces a clean level, one-clock press and release pulses, and a one-shot long-press pulse.
- Replaces per-button debounce instances with a single bank.

Parameters:
- NUM_CH, 4: number of independent channels.
- DEPTH, 8: consecutive equal samples required to change the clean level; legal range 2..32.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range 2..3.
- HOLD_TICKS, 1000: enable ticks with the clean level high before long_press fires (1000 = 1 s); must be >= 1.

Ports:
- Clk100MHz, input, 1: system clock.
- reset_n, input, 1: synchronous, active-low reset.
- Clk1KHzEn, input, 1: one-clock sample enable, nominally 1 kHz.
- sig, input, NUM_CH: raw asynchronous inputs; bit i is channel i.
- sig_clean, output, NUM_CH: debounced level.
- rise_pulse, output, NUM_CH: one-clock pulse on each clean 0->1 change.
- fall_pulse, output, NUM_CH: one-clock pulse on each clean 1->0 change.
- long_press, output, NUM_CH: one-clock pulse when a press has lasted HOLD_TICKS ticks.

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is Clk100MHz. While reset_n=0 at a rising edge, every register clears to 0: synchronisers, shift registers, sig_clean, the clean delay flop, hold counters, and all pulse outputs. Reset takes priority over the enable at any point, including mid-filter and mid-count.
- Synchroniser: a SYNC_STAGES-deep flop chain clocked every Clk100MHz cycle, not gated by the enable. s_i denotes its last stage.
- Shift register (per channel, DEPTH bits): on each clock with Clk1KHzEn=1, shift left and insert s_i at bit 0. It holds when the enable is low.
- Clean level, evaluated on enable clocks against the pre-shift register contents:
  - all ones -> sig_clean=1;
  - all zeros -> sig_clean=0;
  - otherwise hold.
- Clean-level latency: s_i stable from enable tick k onward changes sig_clean at tick k+DEPTH. A glitch shorter than DEPTH ticks never changes sig_clean.
- Edge pulses: c_d = sig_clean delayed one clock, every clock.
  - rise_pulse = sig_clean & ~c_d, registered, so it occurs one clock after the sig_clean change.
  - fall_pulse = ~sig_clean & c_d, registered, same timing.
  - Each pulse is exactly one Clk100MHz cycle wide, never stretched by the enable.
- Hold counter (per channel), width clog2(HOLD_TICKS+1), updated on enable clocks using the pre-update sig_clean:
  - sig_clean=0 -> count<=0;
  - else if count<HOLD_TICKS -> count<=count+1;
  - else saturate.
- long_press: asserted for exactly one clock, in the clock after count reaches HOLD_TICKS. It fires at most once per press.
- Release before HOLD_TICKS: no long_press. A new press restarts the count from 0.
- Simultaneous events:
  - Enable high on the same clock as reset_n=0: reset wins.
  - Enable held high for several consecutive clocks: each clock is a sample; this is legal and used by the bench.
  - Channels are fully independent; several channels may pulse in the same clock.
- Output timing: all outputs are registered; there are no combinational paths from sig to any output.

Decomposition:
- debounce_pkg holds:
  - a clog2 constant function;
  - default parameter constants (DB_DEPTH_DEF=8, DB_SYNC_DEF=2, DB_HOLD_DEF=1000).
- One sub-module, debounce_ch. It contains the single-channel synchroniser, shift register, clean flop, edge flops and hold counter, parametrised by DEPTH, SYNC_STAGES and HOLD_TICKS.
- debounce_bank instantiates NUM_CH copies of debounce_ch in a generate loop and wires the enable and reset to all of them.

Test Plan:
Bench parameters: NUM_CH=2, DEPTH=4, SYNC_STAGES=2, HOLD_TICKS=5, enable pulsed one clock in every 4.
- Reset: hold reset_n=0 with sig=2'b11 and the enable running -> all outputs 0 throughout. Release reset -> sig_clean[0] rises at the 4th tick after the synchronised 1 first reaches the shift register.
- Glitch rejection: ch0 high for 3 ticks then low -> sig_clean[0] stays 0; rise_pulse[0] never asserts.
- Clean press: ch0 rises and stays high -> rise_pulse[0] high for exactly one clock, one clock after sig_clean[0]=1. Later ch0 falls and stays low -> fall_pulse[0] is a single clock one clock after sig_clean[0]=0.
- Long press: ch1 held for 12 ticks after its clean rise -> exactly one long_press[1] pulse, one clock after the 5th tick with sig_clean[1]=1; no second pulse.
- Short press: ch1 released after 3 clean-high ticks -> no long_press[1]. Re-pressing ch1 restarts the count, and long_press[1] fires after 5 further clean-high ticks.
- Reset mid-operation: assert reset_n=0 for 1 clock while ch0 is clean high with count=3 -> sig_clean, the counter and the pulses are 0 on the next clock, with no fall_pulse. With the input still high, sig_clean[0] re-rises after DEPTH ticks plus the synchroniser delay.
